// File: rtl/back_icon_rx_port.sv
// back_icon_rx_port: receiving endpoint of the backend interconnect for one EU.
// Grants at most one channel per cycle, with the lowest channel index winning.
// Accepted operands go into an in-order FIFO that the EU drains with valid/ready.
module back_icon_rx_port #(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int TAG_WIDTH         = 8,
  parameter int LOG2_BUF_DEPTH    = 2
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_ICON_CHANNELS-1:0]                 ch_rx_req_i,
  input  logic [NUM_ICON_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data_i,
  input  logic [NUM_ICON_CHANNELS-1:0][TAG_WIDTH-1:0]  ch_src_tag_i,
  output logic [NUM_ICON_CHANNELS-1:0]                 ch_success_o,
  output logic [DATA_WIDTH-1:0]                        rx_data_o,
  output logic [TAG_WIDTH-1:0]                         rx_tag_o,
  output logic                                         rx_valid_o,
  input  logic                                         rx_ready_i,
  output logic [LOG2_BUF_DEPTH:0]                      occupancy_o,
  output logic                                         overflow_drop_o
);

  localparam int DEPTH = 2 ** LOG2_BUF_DEPTH;
  localparam int IDXW  = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;
  localparam logic [LOG2_BUF_DEPTH:0] FULL_COUNT = DEPTH[LOG2_BUF_DEPTH:0];

  logic [DATA_WIDTH-1:0]     r_data_mem [DEPTH];
  logic [TAG_WIDTH-1:0]      r_tag_mem  [DEPTH];
  logic [LOG2_BUF_DEPTH-1:0] r_rd_ptr;
  logic [LOG2_BUF_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_BUF_DEPTH:0]   r_count;

  logic                          w_any_req;
  logic                          w_multi_req;
  logic                          w_full;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_valid;
  logic [IDXW-1:0]               w_grant_idx;
  logic [NUM_ICON_CHANNELS-1:0]  w_grant_onehot;

  // Fullness looks only at the registered count, so a same-cycle pop never
  // frees a slot and rx_ready_i has no path into the grant.
  assign w_full      = (r_count == FULL_COUNT);
  assign w_any_req   = |ch_rx_req_i;
  assign w_multi_req = |(ch_rx_req_i & (ch_rx_req_i - 1'b1));
  assign w_valid     = (r_count != '0);
  assign w_push      = reset_n & w_any_req & ~w_full;
  assign w_pop       = w_valid & rx_ready_i;

  // Priority encoder: scan from high index down so that the lowest requester wins.
  always_comb begin
    w_grant_idx = '0;
    for (int c = NUM_ICON_CHANNELS - 1; c >= 0; c--) begin
      if (ch_rx_req_i[c]) begin
        w_grant_idx = c[IDXW-1:0];
      end
    end
  end

  // Build the one-hot success vector from the winning index, gated by push.
  always_comb begin
    w_grant_onehot = '0;
    if (w_push) begin
      w_grant_onehot[w_grant_idx] = 1'b1;
    end
  end

  assign ch_success_o    = w_grant_onehot;
  assign overflow_drop_o = reset_n & w_any_req & (w_full | w_multi_req);

  assign rx_valid_o  = w_valid;
  assign rx_data_o   = w_valid ? r_data_mem[r_rd_ptr] : '0;
  assign rx_tag_o    = w_valid ? r_tag_mem[r_rd_ptr]  : '0;
  assign occupancy_o = r_count;

  // Pointers and count. Reset discards all held entries, including any in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage write of the granted channel's payload and tag. The storage is not
  // cleared on reset because the outputs are masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= ch_data_i[w_grant_idx];
      r_tag_mem[r_wr_ptr]  <= ch_src_tag_i[w_grant_idx];
    end
  end

endmodule
